// File: rtl/pc_gen_ras.sv
// ---------------------------------------------------------------------------
// pc_gen_ras -- MIPS fetch-stage program-counter generator with a circular
// return-address stack (RAS) and an optional halt detector.
//
// Optional feature macro: PC_HALT_EN
//   defined   : fetch freezes once nxt_pc>>2 == HALT_PC; pc_halted goes sticky.
//   undefined : pc_halted is tied 0, HALT_PC is ignored.
//
// Parameters
//   ADDR_W    : PC width (28..64)
//   RESET_PC  : cur_pc value on reset (low 2 bits zero)
//   RAS_DEPTH : RAS entries (power of two, 2..32)
//   HALT_PC   : word index that halts fetch (PC_HALT_EN only)
//
// Ports
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   stall           : hold PC and RAS, suppress every redirect
//   br_taken/target : resolved branch redirect (target low bits forced to 00)
//   jump, call, ret : J, JAL (push) and JR $ra (pop) redirects
//   jump_imm        : 26-bit jump/call immediate
//   clr_err         : clear sticky RAS flags
//   cur_pc          : registered PC
//   pc_plus_4       : cur_pc + 4 (wrapping)
//   nxt_pc          : combinational next PC
//   ras_top         : top RAS entry, 0 when empty
//   ras_count       : number of valid RAS entries
//   ras_overflow    : sticky, a push overwrote the oldest entry
//   ras_underflow   : sticky, a pop found the RAS empty
//   pc_halted       : sticky halt indication
// ---------------------------------------------------------------------------
module pc_gen_ras #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] HALT_PC   = ADDR_W'(5)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         br_taken,
  input  logic [ADDR_W-1:0]            br_target,
  input  logic                         jump,
  input  logic                         call,
  input  logic                         ret,
  input  logic [25:0]                  jump_imm,
  input  logic                         clr_err,
  output logic [ADDR_W-1:0]            cur_pc,
  output logic [ADDR_W-1:0]            pc_plus_4,
  output logic [ADDR_W-1:0]            nxt_pc,
  output logic [ADDR_W-1:0]            ras_top,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow,
  output logic                         pc_halted
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

`ifdef PC_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  // architectural state
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;
  logic              r_unf;
  logic              r_halted;

  // combinational helpers
  logic [ADDR_W-1:0] w_ppc;
  logic [ADDR_W-1:0] w_jaddr;
  logic [ADDR_W-1:0] w_br;
  logic [ADDR_W-1:0] w_top_entry;
  logic [ADDR_W-1:0] w_nxt;
  logic              w_empty;
  logic              w_full;
  logic              w_frozen;
  logic              w_run;
  logic              w_halt_hit;

  // RAS next-state controls
  logic              w_we;
  logic [PTR_W-1:0]  w_waddr;
  logic [PTR_W-1:0]  w_ptr_n;
  logic [CNT_W-1:0]  w_cnt_n;
  logic              w_ovf_evt;
  logic              w_unf_evt;

  assign w_ppc       = r_pc + ADDR_W'(4);
  assign w_br        = br_target & ~ADDR_W'(3);
  assign w_empty     = (r_cnt == '0);
  assign w_full      = (r_cnt == FULL_CNT);
  assign w_top_entry = r_ras[r_ptr];
  assign w_frozen    = HALT_EN && r_halted;
  assign w_run       = !stall && !w_frozen;

  // Region bits above the 28-bit jump window exist only when ADDR_W > 28.
  generate
    if (ADDR_W > 28) begin : g_jaddr_wide
      assign w_jaddr = {w_ppc[ADDR_W-1:28], jump_imm, 2'b00};
    end else begin : g_jaddr_narrow
      assign w_jaddr = {jump_imm, 2'b00};
    end
  endgenerate

  // next-PC priority: stall/halt > ret > call|jump > branch > sequential
  always_comb begin
    w_nxt = w_ppc;
    if (!w_run) begin
      w_nxt = r_pc;
    end else if (ret) begin
      w_nxt = w_empty ? w_ppc : w_top_entry;
    end else if (call || jump) begin
      w_nxt = w_jaddr;
    end else if (br_taken) begin
      w_nxt = w_br;
    end
  end

  // RAS control. The pointer always addresses the current top; a push writes
  // one slot above it. A call+ret on an empty stack degenerates into a push.
  always_comb begin
    w_we      = 1'b0;
    w_waddr   = r_ptr;
    w_ptr_n   = r_ptr;
    w_cnt_n   = r_cnt;
    w_ovf_evt = 1'b0;
    w_unf_evt = 1'b0;
    if (w_run) begin
      if (call && (!ret || w_empty)) begin
        w_we    = 1'b1;
        w_waddr = r_ptr + PTR_W'(1);
        w_ptr_n = r_ptr + PTR_W'(1);
        if (w_full) begin
          // pointer wrap overwrites the oldest entry
          w_ovf_evt = 1'b1;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
        if (ret) begin
          w_unf_evt = 1'b1;
        end
      end else if (call && ret) begin
        // replace top in place: return consumes it, call refills it
        w_we    = 1'b1;
        w_waddr = r_ptr;
      end else if (ret) begin
        if (w_empty) begin
          w_unf_evt = 1'b1;
        end else begin
          w_ptr_n = r_ptr - PTR_W'(1);
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
    end
  end

  assign w_halt_hit = HALT_EN && w_run && ((w_nxt >> 2) == HALT_PC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_pc  <= w_nxt;
      r_ptr <= w_ptr_n;
      r_cnt <= w_cnt_n;
      if (!w_frozen) begin
        // a same-cycle event beats clr_err
        r_ovf <= w_ovf_evt | (r_ovf & ~clr_err);
        r_unf <= w_unf_evt | (r_unf & ~clr_err);
      end
      if (w_halt_hit) begin
        r_halted <= 1'b1;
      end
    end
  end

  // entry storage carries no reset; contents are qualified by r_cnt
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_ras[w_waddr] <= w_ppc;
    end
  end

  assign cur_pc        = r_pc;
  assign pc_plus_4     = w_ppc;
  assign nxt_pc        = w_nxt;
  assign ras_top       = w_empty ? '0 : w_top_entry;
  assign ras_count     = r_cnt;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;
  assign pc_halted     = HALT_EN ? r_halted : 1'b0;

endmodule

// File: tb/tb_pc_gen_ras.sv
// ---------------------------------------------------------------------------
// tb_pc_gen_ras -- directed bench for pc_gen_ras (ADDR_W=32, RESET_PC=0x100,
// RAS_DEPTH=4). A queue-based reference model is compared against the DUT on
// every negative clock edge; literal expectations along the directed sequence
// pin the model itself.
// ---------------------------------------------------------------------------
module tb_pc_gen_ras;

  localparam int unsigned    DEPTH = 4;
  localparam logic [31:0]    RST_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br_taken, jump, call, ret, clr_err;
  logic [31:0] br_target;
  logic [25:0] jump_imm;
  logic [31:0] cur_pc, pc_plus_4, nxt_pc, ras_top;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow, pc_halted;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  bit          chk_en  = 1'b0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_stk [$];
  logic        m_ovf, m_unf, m_halt;

  pc_gen_ras #(
    .ADDR_W   (32),
    .RESET_PC (RST_PC),
    .RAS_DEPTH(DEPTH),
    .HALT_PC  (32'd5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .jump         (jump),
    .call         (call),
    .ret          (ret),
    .jump_imm     (jump_imm),
    .clr_err      (clr_err),
    .cur_pc       (cur_pc),
    .pc_plus_4    (pc_plus_4),
    .nxt_pc       (nxt_pc),
    .ras_top      (ras_top),
    .ras_count    (ras_count),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow),
    .pc_halted    (pc_halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_pp();
    logic [31:0] v;
    v = m_pc + 32'd4;
    return v;
  endfunction

  // next PC straight from the priority rules
  function automatic logic [31:0] m_nxt();
    logic [31:0] pp;
    logic [31:0] j;
    pp = m_pp();
    j  = {pp[31:28], jump_imm, 2'b00};
    if (m_halt || stall)  return m_pc;
    if (ret)              return (m_stk.size() == 0) ? pp : m_stk[m_stk.size()-1];
    if (call || jump)     return j;
    if (br_taken)         return {br_target[31:2], 2'b00};
    return pp;
  endfunction

  function automatic logic [31:0] m_top();
    if (m_stk.size() == 0) return 32'h0;
    return m_stk[m_stk.size()-1];
  endfunction

  // model update
  initial begin
    logic [31:0] nx;
    logic [31:0] pp;
    logic oe, ue;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pc = RST_PC;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_halt = 1'b0;
      end else if (!m_halt) begin
        oe = 1'b0;
        ue = 1'b0;
        if (!stall) begin
          nx = m_nxt();
          pp = m_pp();
          if (ret && call) begin
            if (m_stk.size() == 0) begin
              m_stk.push_back(pp);
              ue = 1'b1;
            end else begin
              m_stk[m_stk.size()-1] = pp;
            end
          end else if (ret) begin
            if (m_stk.size() == 0) ue = 1'b1;
            else void'(m_stk.pop_back());
          end else if (call) begin
            if (m_stk.size() == DEPTH) begin
              void'(m_stk.pop_front());
              oe = 1'b1;
            end
            m_stk.push_back(pp);
          end
`ifdef PC_HALT_EN
          if ((nx >> 2) == 32'd5) m_halt = 1'b1;
`endif
          m_pc = nx;
        end
        m_ovf = oe | (m_ovf & !clr_err);
        m_unf = ue | (m_unf & !clr_err);
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("cur_pc",        cur_pc,        m_pc);
      chk("pc_plus_4",     pc_plus_4,     m_pp());
      chk("nxt_pc",        nxt_pc,        m_nxt());
      chk("ras_top",       ras_top,       m_top());
      chk("ras_count",     ras_count,     m_stk.size());
      chk("ras_overflow",  ras_overflow,  m_ovf);
      chk("ras_underflow", ras_underflow, m_unf);
      chk("pc_halted",     pc_halted,     m_halt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; br_taken = 1'b0; jump = 1'b0;
    call = 1'b0; ret = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0] call_imm [5];
    logic [31:0] call_exp [5];
    logic [31:0] ret_exp  [5];
    call_imm = '{26'h4, 26'h8, 26'hC, 26'h10, 26'h20};
    call_exp = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h80};
    ret_exp  = '{32'h44, 32'h34, 32'h24, 32'h14, 32'h18};

    idle();
    br_target = '0;
    jump_imm  = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cur_pc", cur_pc, 32'h100);
    chk("rst_count",  ras_count, 0);
    chk("rst_top",    ras_top, 0);
    chk("rst_ovf",    ras_overflow, 0);
    chk("rst_unf",    ras_underflow, 0);
    chk("rst_halt",   pc_halted, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    chk("free0", cur_pc, 32'h100);
    cyc(); chk("free1", cur_pc, 32'h104);
    cyc(); chk("free2", cur_pc, 32'h108);
    cyc(); chk("free3", cur_pc, 32'h10C);
    chk("free_count", ras_count, 0);

    // jump to 0x40, then branch held off by stall
    jump = 1'b1; jump_imm = 26'h10;
    cyc(); chk("jump_40", cur_pc, 32'h40);
    jump = 1'b0; stall = 1'b1; br_taken = 1'b1; br_target = 32'h203;
    #1 chk("stall_nxt", nxt_pc, 32'h40);
    cyc(); chk("stall_hold", cur_pc, 32'h40);
    stall = 1'b0;
    #1 chk("br_nxt", nxt_pc, 32'h200);
    cyc(); chk("br_taken", cur_pc, 32'h200);

    // jump outranks branch
    jump = 1'b1; jump_imm = 26'h0; br_target = 32'h500;
    cyc(); chk("jump_over_br", cur_pc, 32'h0);
    idle();

    // five calls into a four-deep RAS
    call = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      jump_imm = call_imm[i];
      cyc(); chk("call_pc", cur_pc, call_exp[i]);
    end
    chk("call_count", ras_count, 4);
    chk("call_ovf",   ras_overflow, 1);
    chk("call_top",   ras_top, 32'h44);
    call = 1'b0;

    // five returns, last one on an empty stack
    ret = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      cyc(); chk("ret_pc", cur_pc, ret_exp[i]);
    end
    chk("ret_count", ras_count, 0);
    chk("ret_unf",   ras_underflow, 1);
    chk("ret_top",   ras_top, 0);

    // clear coinciding with another underflow: underflow stays, overflow clears
    clr_err = 1'b1;
    cyc();
    chk("clr_evt_pc",  cur_pc, 32'h1C);
    chk("clr_evt_ovf", ras_overflow, 0);
    chk("clr_evt_unf", ras_underflow, 1);
    ret = 1'b0;
    cyc();
    chk("clr_unf", ras_underflow, 0);
    chk("clr_pc",  cur_pc, 32'h20);
    clr_err = 1'b0;

    // call+ret with top=0x104 at cur_pc=0x300
    jump = 1'b1; jump_imm = 26'h40;
    cyc(); chk("to_100", cur_pc, 32'h100);
    jump = 1'b0; call = 1'b1; jump_imm = 26'h80;
    cyc(); chk("call_200", cur_pc, 32'h200);
    call = 1'b0; jump = 1'b1; jump_imm = 26'hC0;
    cyc(); chk("to_300", cur_pc, 32'h300);
    chk("pre_cr_top", ras_top, 32'h104);
    jump = 1'b0; call = 1'b1; ret = 1'b1; jump_imm = 26'h0;
    cyc();
    chk("cr_pc",    cur_pc, 32'h104);
    chk("cr_top",   ras_top, 32'h304);
    chk("cr_count", ras_count, 1);
    call = 1'b0;
    cyc(); chk("cr_pop", cur_pc, 32'h304);
    call = 1'b1;
    cyc();
    chk("cr_empty_pc",  cur_pc, 32'h308);
    chk("cr_empty_cnt", ras_count, 1);
    chk("cr_empty_top", ras_top, 32'h308);
    chk("cr_empty_unf", ras_underflow, 1);
    idle();

    // address wrap and high region bits in the jump address
    br_taken = 1'b1; br_target = 32'hFFFF_FFFD;
    cyc(); chk("br_top", cur_pc, 32'hFFFF_FFFC);
    br_taken = 1'b0;
    #1 chk("wrap_pp4", pc_plus_4, 32'h0);
    cyc(); chk("wrap_pc", cur_pc, 32'h0);
    br_taken = 1'b1; br_target = 32'hF000_0000;
    cyc();
    br_taken = 1'b0; jump = 1'b1; jump_imm = 26'h1;
    cyc(); chk("jump_region", cur_pc, 32'hF000_0004);
    jump = 1'b0;

    // reach count=3 with overflow set, then reset mid-cycle
    call = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      jump_imm = 26'(i + 1);
      cyc();
    end
    call = 1'b0; ret = 1'b1;
    cyc();
    ret = 1'b0;
    chk("pre_rst_count", ras_count, 3);
    chk("pre_rst_ovf",   ras_overflow, 1);
    call = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pc",    cur_pc, 32'h100);
    chk("arst_count", ras_count, 0);
    chk("arst_ovf",   ras_overflow, 0);
    chk("arst_top",   ras_top, 0);
    idle();
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc(); chk("post_rst", cur_pc, 32'h104);

    // sequential fetch from 0 across the halt word index
    jump = 1'b1; jump_imm = 26'h0;
    cyc(); chk("seq0", cur_pc, 32'h0);
    jump = 1'b0;
    for (int unsigned i = 1; i <= 5; i++) begin
      cyc(); chk("seq_pc", cur_pc, 32'(i * 4));
    end
`ifdef PC_HALT_EN
    chk("halt_set", pc_halted, 1);
    jump = 1'b1; call = 1'b1; br_taken = 1'b1; jump_imm = 26'h40;
    cyc(); chk("halt_hold1", cur_pc, 32'h14);
    ret = 1'b1; jump = 1'b0;
    cyc(); chk("halt_hold2", cur_pc, 32'h14);
    chk("halt_count", ras_count, 0);
    idle();
    rst_n = 1'b0;
    #1 chk("halt_rst", pc_halted, 0);
    rst_n = 1'b1;
`else
    chk("nohalt_flag", pc_halted, 0);
    cyc(); chk("nohalt_18", cur_pc, 32'h18);
`endif

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen_ras.md
# pc_gen_ras

Parametrised program-counter generator for the MIPS fetch stage. It produces the current PC, the sequential PC and the next-PC selection for branch, jump, call and return. Unlike the fixed 32-bit PC, it adds a configurable reset vector, a circular return-address stack (RAS) for call/return prediction with sticky error flags, and an optional halt detector. It sits between the decode/branch-resolve logic and the instruction-memory address port.

## Interface
- ADDR_W, 32: PC width; legal range 28..64.
- RESET_PC, 0: value loaded into cur_pc on reset; low 2 bits must be 0.
- RAS_DEPTH, 4: RAS entries; power of two, 2..32.
- HALT_PC, 5: word index (address>>2) that halts fetch; used only with PC_HALT_EN.

- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard hold; freezes PC and RAS, suppresses all redirects.
- br_taken  in  1  resolved branch taken.
- br_target  in  ADDR_W  branch target address.
- jump  in  1  J-type jump.
- call  in  1  JAL: jump and push return address.
- ret  in  1  JR $ra: pop RAS and redirect.
- jump_imm  in  26  instruction immediate for jump/call.
- clr_err  in  1  clears the sticky RAS flags.
- cur_pc  out  ADDR_W  registered PC.
- pc_plus_4  out  ADDR_W  cur_pc+4, modulo 2^ADDR_W.
- nxt_pc  out  ADDR_W  combinational next PC.
- ras_top  out  ADDR_W  current top entry; 0 when empty.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid entries.
- ras_overflow  out  1  sticky: a push overwrote an entry.
- ras_underflow  out  1  sticky: a pop occurred when empty.
- pc_halted  out  1  sticky halt indication.

## Operation
- Jump address: {pc_plus_4[ADDR_W-1:28], jump_imm, 2'b00}. When ADDR_W==28, it is {jump_imm, 2'b00}.
- br_target has its low 2 bits forced to 00.
- nxt_pc priority:
  - stall → cur_pc.
  - ret → popped value. If the RAS is empty, the pop yields pc_plus_4.
  - call or jump → jump address.
  - br_taken → br_target.
  - otherwise → pc_plus_4.
- RAS is a circular buffer with a top pointer. All RAS operations are suppressed when stall=1.
  - Push (call=1, ret=0): writes pc_plus_4 at top+1 and advances the pointer.
  - Push when full: overwrites the oldest entry. The pointer wraps, ras_count stays at RAS_DEPTH, and ras_overflow sets.
  - Pop (ret=1, call=0): reads the top entry and decrements the pointer and count.
  - Pop when empty: count stays 0, ras_underflow sets, and the target is pc_plus_4.
  - call and ret together: ret wins the redirect. The top entry is replaced with pc_plus_4, count is unchanged, and the target is the old top. If the RAS is empty, this acts as a push; ras_underflow sets and the target is pc_plus_4.
- clr_err=1 clears both sticky flags next cycle. A flag event in the same cycle wins, so the flag stays set.
- Arithmetic wraps modulo 2^ADDR_W, with no carry out.

## Timing
- nxt_pc, pc_plus_4 and ras_top are combinational from cur_pc, the inputs and RAS state within the same cycle.
- cur_pc, the RAS, ras_count and the flags update on the rising clk edge. Redirect latency is 1 cycle.
- Reset asserted, asynchronous and at any time including mid-call or mid-stall:
  - cur_pc = RESET_PC.
  - RAS pointer and ras_count = 0.
  - ras_top = 0.
  - ras_overflow, ras_underflow and pc_halted = 0.
  - RAS entry contents are don't-care.
- Reset deassertion takes effect on the first rising edge after rst_n=1.

## Configuration
- PC_HALT_EN defined:
  - When stall=0 and nxt_pc>>2 == HALT_PC, cur_pc loads nxt_pc and pc_halted sets.
  - From the following cycle, cur_pc and the RAS freeze until reset, and all inputs are ignored.
- PC_HALT_EN undefined:
  - pc_halted is tied to 0 and HALT_PC is ignored.
  - Fetch never freezes except via stall.

## Test plan
- Reset with RESET_PC=0x100, then 3 free cycles → cur_pc 0x100, 0x104, 0x108, 0x10C; ras_count=0; all flags 0.
- At cur_pc=0x40, br_taken=1 with br_target=0x203 while stall=1 → cur_pc stays 0x40. Deassert stall → next cur_pc=0x200 (low bits cleared).
- RAS_DEPTH=4: 5 calls at cur_pc 0x0, 0x10, 0x20, 0x30, 0x40 → ras_count=4, ras_overflow=1. Then 5 rets → targets 0x44, 0x34, 0x24, 0x14, then an empty pop returns pc_plus_4 and ras_underflow=1.
- With top=0x104, call+ret at cur_pc=0x300 → next cur_pc=0x104, ras_top=0x304, ras_count unchanged.
- With PC_HALT_EN defined, sequential fetch from 0 → cur_pc reaches 0x14, pc_halted=1, and cur_pc stays 0x14 under any stimulus until rst_n=0. Without PC_HALT_EN, cur_pc continues to 0x18.
- Assert rst_n=0 mid-cycle with ras_count=3 and ras_overflow=1 → immediately cur_pc=RESET_PC, ras_count=0, ras_overflow=0.
